// File: rtl/npc_pkg.sv
// Shared constants for the instruction fetch unit: FSM state encoding and reset vector.
package npc_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned RETIRE_W  = 64;
    localparam int unsigned ADDR_LSBS = 2;

    typedef logic [STATE_W-1:0] state_t;

    // Fetch FSM states
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // A fetch target must be word aligned
    function automatic logic misaligned(input logic [ADDR_LSBS-1:0] low);
        return low != '0;
    endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one instruction in flight, REQ -> WAIT -> HOLD loop,
// terminal ERR on access fault or misaligned next pc.
module ifu
    import npc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    input  logic [DATA_WIDTH-1:0] dnpc,
    output logic                  fetch_err,
    output logic [RETIRE_W-1:0]   retire_cnt
);

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] pc_nxt;
    logic [DATA_WIDTH-1:0] inst_nxt;
    logic                  err_nxt;
    logic [RETIRE_W-1:0]   cnt_nxt;
    logic                  req_valid_nxt;
    logic                  inst_valid_nxt;

    // The request address is the pc register itself, so it is stable while stalled
    assign imem_req_addr = pc;

    // State and all registered outputs; reset forces everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_REQ;
            pc             <= RESET_PC;
            inst           <= '0;
            fetch_err      <= 1'b0;
            retire_cnt     <= '0;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            inst           <= inst_nxt;
            fetch_err      <= err_nxt;
            retire_cnt     <= cnt_nxt;
            imem_req_valid <= req_valid_nxt;
            inst_valid     <= inst_valid_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        inst_nxt       = inst;
        err_nxt        = fetch_err;
        cnt_nxt        = retire_cnt;
        req_valid_nxt  = 1'b0;
        inst_valid_nxt = 1'b0;

        case (state)
            ST_REQ: begin
                // imem_req_valid is low for the first cycle out of reset, so gate on it
                if (imem_req_valid && imem_req_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_ERR;
                    end else begin
                        inst_nxt  = imem_rsp_data;
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (inst_valid && inst_ready) begin
                    pc_nxt  = dnpc;
                    cnt_nxt = retire_cnt + RETIRE_W'(1);
                    if (misaligned(dnpc[ADDR_LSBS-1:0])) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_ERR;
                    end else begin
                        state_nxt = ST_REQ;
                    end
                end
            end
            ST_ERR: begin
                state_nxt = ST_ERR;
            end
            default: begin
                state_nxt = ST_ERR;
            end
        endcase

        // Handshake outputs follow the state being entered
        req_valid_nxt  = (state_nxt == ST_REQ);
        inst_valid_nxt = (state_nxt == ST_HOLD);
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios then randomized traffic against a
// transaction-level reference model.
module tb_ifu;

    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] RPC = 32'h8000_0000;

    logic          clk;
    logic          rst;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [DW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [DW-1:0] imem_rsp_data;
    logic          imem_rsp_err;
    logic [DW-1:0] pc;
    logic [DW-1:0] inst;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] dnpc;
    logic          fetch_err;
    logic [63:0]   retire_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: what has happened so far, in transaction terms
    logic [DW-1:0] m_pc;
    logic [DW-1:0] m_inst;
    logic [63:0]   m_cnt;
    logic          m_dead;   // fault seen, frozen until reset
    logic          m_outst;  // request accepted, response pending
    logic          m_have;   // instruction held for decode
    logic          m_live;   // at least one clock since reset

    ifu #(.RESET_PC(RPC), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .pc             (pc),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .dnpc           (dnpc),
        .fetch_err      (fetch_err),
        .retire_cnt     (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_pc    = RPC;
        m_inst  = '0;
        m_cnt   = '0;
        m_dead  = 1'b0;
        m_outst = 1'b0;
        m_have  = 1'b0;
        m_live  = 1'b0;
    endtask

    // Advance the model across one clock edge using the inputs currently driven
    task automatic m_edge();
        logic req_vis;
        req_vis = m_live && !m_dead && !m_outst && !m_have;
        if (m_dead) begin
            m_dead = 1'b1;
        end else if (m_have) begin
            if (inst_ready) begin
                m_cnt = m_cnt + 64'd1;
                m_pc  = dnpc;
                if (dnpc[1:0] != 2'b00) m_dead = 1'b1;
                else                    m_have = 1'b0;
            end
        end else if (m_outst) begin
            if (imem_rsp_valid) begin
                m_outst = 1'b0;
                if (imem_rsp_err) begin
                    m_dead = 1'b1;
                end else begin
                    m_inst = imem_rsp_data;
                    m_have = 1'b1;
                end
            end
        end else if (req_vis && imem_req_ready) begin
            m_outst = 1'b1;
        end
        m_live = 1'b1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".req_valid"},  64'(imem_req_valid), 64'(m_live && !m_dead && !m_outst && !m_have));
        chk({tag, ".req_addr"},   64'(imem_req_addr),  64'(m_pc));
        chk({tag, ".inst_valid"}, 64'(inst_valid),     64'(m_have && !m_dead));
        chk({tag, ".pc"},         64'(pc),             64'(m_pc));
        chk({tag, ".inst"},       64'(inst),           64'(m_inst));
        chk({tag, ".fetch_err"},  64'(fetch_err),      64'(m_dead));
        chk({tag, ".retire_cnt"}, retire_cnt,          m_cnt);
    endtask

    initial begin
        logic [DW-1:0] d;

        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        dnpc           = '0;

        // Asynchronous reset, observed before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst.req_valid",  64'(imem_req_valid), 64'd0);
        chk("rst.inst_valid", 64'(inst_valid),     64'd0);
        chk("rst.pc",         64'(pc),             64'(RPC));
        chk("rst.inst",       64'(inst),           64'd0);
        chk("rst.fetch_err",  64'(fetch_err),      64'd0);
        chk("rst.retire_cnt", retire_cnt,          64'd0);
        step();
        step();
        chk("rst_held.req_valid", 64'(imem_req_valid), 64'd0);

        // Release with ready high; response one cycle after acceptance
        rst = 1'b0;
        imem_req_ready = 1'b1;
        step();
        chk("c1.req_valid", 64'(imem_req_valid), 64'd1);
        chk("c1.req_addr",  64'(imem_req_addr),  64'(RPC));
        chk("c1.inst_valid", 64'(inst_valid),    64'd0);
        step();
        chk("c2.req_valid", 64'(imem_req_valid), 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0073;
        step();
        chk("c3.inst_valid", 64'(inst_valid), 64'd1);
        chk("c3.pc",         64'(pc),         64'h8000_0000);
        chk("c3.inst",       64'(inst),       64'h0010_0073);

        // Decode stall, then handshake to an aligned next pc
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        inst_ready     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.inst_valid", 64'(inst_valid),     64'd1);
            chk("stall.inst",       64'(inst),           64'h0010_0073);
            chk("stall.req_valid",  64'(imem_req_valid), 64'd0);
        end
        imem_rsp_valid = 1'b0;
        inst_ready = 1'b1;
        dnpc       = 32'h8000_0010;
        step();
        inst_ready = 1'b0;
        chk("hs.req_valid",  64'(imem_req_valid), 64'd1);
        chk("hs.req_addr",   64'(imem_req_addr),  64'h8000_0010);
        chk("hs.retire_cnt", retire_cnt,          64'd1);
        chk("hs.inst_valid", 64'(inst_valid),     64'd0);

        // Reset in WAIT abandons the request; late response ignored; stalled fresh request
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("wait.req_valid", 64'(imem_req_valid), 64'd0);
        rst = 1'b1;
        #1;
        chk("midrst.pc",         64'(pc),         64'(RPC));
        chk("midrst.retire_cnt", retire_cnt,      64'd0);
        chk("midrst.inst",       64'(inst),       64'd0);
        step();
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hdead_beef;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("nordy.req_valid",  64'(imem_req_valid), 64'd1);
            chk("nordy.req_addr",   64'(imem_req_addr),  64'h8000_0000);
            chk("nordy.inst_valid", 64'(inst_valid),     64'd0);
            chk("nordy.inst",       64'(inst),           64'd0);
        end
        imem_rsp_valid = 1'b0;

        // Access fault is terminal
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        step();
        chk("fault.fetch_err", 64'(fetch_err),      64'd1);
        chk("fault.req_valid", 64'(imem_req_valid), 64'd0);
        imem_rsp_err   = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dead.req_valid",  64'(imem_req_valid), 64'd0);
            chk("dead.inst_valid", 64'(inst_valid),     64'd0);
            chk("dead.fetch_err",  64'(fetch_err),      64'd1);
        end
        imem_rsp_valid = 1'b0;

        // Misaligned next pc from decode
        rst = 1'b1;
        #1;
        chk("rst2.fetch_err", 64'(fetch_err), 64'd0);
        step();
        rst = 1'b0;
        step();
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        step();
        imem_rsp_valid = 1'b0;
        chk("mis.hold_inst", 64'(inst), 64'h0000_0013);
        inst_ready = 1'b1;
        dnpc       = 32'h8000_0006;
        step();
        inst_ready = 1'b0;
        chk("mis.fetch_err",  64'(fetch_err),      64'd1);
        chk("mis.pc",         64'(pc),             64'h8000_0006);
        chk("mis.req_valid",  64'(imem_req_valid), 64'd0);
        chk("mis.inst_valid", 64'(inst_valid),     64'd0);
        chk("mis.retire_cnt", retire_cnt,          64'd1);
        imem_req_ready = 1'b1;
        step();
        chk("mis_dead.req_valid", 64'(imem_req_valid), 64'd0);

        // Randomized traffic against the reference model
        rst = 1'b1;
        #1;
        m_reset();
        step();
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (($urandom_range(0, 299) == 0) || (m_dead && $urandom_range(0, 7) == 0)) begin
                rst = 1'b1;
                #1;
                m_reset();
                chk_model("rnd_rst");
                step();
                rst = 1'b0;
                chk_model("rnd_rst_hold");
            end else begin
                imem_req_ready = 1'($urandom_range(0, 1));
                imem_rsp_valid = 1'($urandom_range(0, 1));
                imem_rsp_err   = ($urandom_range(0, 31) == 0);
                imem_rsp_data  = $urandom();
                inst_ready     = 1'($urandom_range(0, 1));
                d = $urandom();
                if ($urandom_range(0, 49) != 0) d = d & 32'hFFFF_FFFC;
                dnpc = d;
                m_edge();
                step();
                chk_model("rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the instruction and address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-007 SHALL have port imem_req_addr  output  DATA_WIDTH  fetch address, equal to the pc register.
REQ-008 SHALL have port imem_rsp_valid  input  1  response data valid.
REQ-009 SHALL have port imem_rsp_data  input  DATA_WIDTH  fetched instruction word.
REQ-010 SHALL have port imem_rsp_err  input  1  access fault, qualified by imem_rsp_valid.
REQ-011 SHALL have port pc  output  DATA_WIDTH  pc of the held instruction, to decode.
REQ-012 SHALL have port inst  output  DATA_WIDTH  held instruction, to decode.
REQ-013 SHALL have port inst_valid  output  1  pc/inst valid for decode.
REQ-014 SHALL have port inst_ready  input  1  decode consumes the instruction this cycle.
REQ-015 SHALL have port dnpc  input  DATA_WIDTH  next pc from decode, sampled on handshake.
REQ-016 SHALL have port fetch_err  output  1  sticky fault flag.
REQ-017 SHALL have port retire_cnt  output  64  count of instructions handed to decode.

Function
REQ-018 SHALL implement four states: REQ, WAIT, HOLD, ERR.
REQ-019 In REQ, SHALL drive imem_req_valid=1; on imem_req_ready, SHALL go to WAIT.
REQ-020 SHALL hold imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-021 In WAIT, on imem_rsp_valid with imem_rsp_err=0, SHALL latch imem_rsp_data into inst and go to HOLD; the minimum latency is 1 cycle after acceptance.
REQ-022 In WAIT, on imem_rsp_valid with imem_rsp_err=1, SHALL set fetch_err and go to ERR.
REQ-023 SHALL ignore imem_rsp_valid in every state other than WAIT.
REQ-024 In HOLD, SHALL drive inst_valid=1 and keep pc/inst stable until inst_ready=1.
REQ-025 On HOLD with inst_ready=1, SHALL: load pc<=dnpc; increment retire_cnt by 1 (wrapping at 2^64); go to REQ.
REQ-026 On that handshake, if dnpc[1:0]!=0, SHALL load pc<=dnpc, set fetch_err and go to ERR instead of REQ; retire_cnt still increments.
REQ-027 ERR SHALL be terminal until reset: imem_req_valid=0, inst_valid=0.
REQ-028 SHALL keep inst_valid=0 in REQ, WAIT and ERR, so at most one instruction is in flight.
REQ-029 The throughput bound SHALL be one instruction per 3 cycles with zero-wait memory (REQ, WAIT, HOLD).

Reset
REQ-030 While rst=1, SHALL hold the following values immediately, independent of clk:
- state=REQ, pc=RESET_PC, inst=0
- imem_req_valid=0, inst_valid=0
- fetch_err=0, retire_cnt=0
REQ-031 On the first rising clk edge after rst falls, SHALL assert imem_req_valid for RESET_PC.
REQ-032 A reset asserted during WAIT SHALL abandon the outstanding request; a late response SHALL be ignored per REQ-023.

Structure
REQ-033 The state enum and the RESET_PC default constant SHALL live in shared package npc_pkg.
REQ-034 SHALL be a single flat module; no sub-module is required.

Verification
REQ-035 Scenario: reset release with ready=1 and response valid one cycle later with data 32'h00100073 -> pc=32'h80000000, inst=32'h00100073, inst_valid=1 on cycle 3.
REQ-036 Scenario: imem_req_ready held 0 for 4 cycles -> imem_req_addr stays 32'h80000000 and imem_req_valid stays 1 throughout.
REQ-037 Scenario: in HOLD, inst_ready=0 for 3 cycles, then 1 with dnpc=32'h80000010 -> inst is stable during the stall; next request address is 32'h80000010; retire_cnt=1.
REQ-038 Scenario: response with imem_rsp_err=1 -> fetch_err=1, and no further imem_req_valid until reset.
REQ-039 Scenario: handshake with dnpc=32'h80000006 -> fetch_err=1, state ERR, pc=32'h80000006.
REQ-040 Scenario: rst pulsed mid-WAIT, then a response arrives after release -> response discarded; a fresh request for 32'h80000000 is issued.
